// File: rtl/rr_arb16_ctrl.sv
// Round-robin arbiter sharing one resource among 16 requesters; grant held until done, abort or watchdog.
// Latency: request to registered grant 1 cycle; release to next grant at least 2 idle cycles (REL + IDLE).
// Backpressure: requesters hold i_req until served; a grant is never moved by other requests during GRANT.
module rr_arb16_ctrl #(
  parameter int NREQ    = 16,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_done,
  output logic [NREQ-1:0] o_gnt,
  output logic [3:0]      o_gnt_id,
  output logic            o_gnt_vld,
  output logic            o_busy,
  output logic            o_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_REL   = 2'd2
  } state_t;

  localparam bit             TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic [3:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [3:0]        id_q, id_d;
  logic              vld_q, vld_d;
  logic              to_q, to_d;
  logic [3:0]        pick;
  logic              to_hit;

  // Rotating priority search: the lowest offset from ptr with a pending request wins.
  always_comb begin
    pick = ptr_q;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req[ptr_q + 4'(i)]) begin
        pick = ptr_q + 4'(i);
      end
    end
  end

  assign to_hit = TO_EN && (cnt_q == TO_LAST);

  // Next-state and registered-output logic for the IDLE/GRANT/REL controller.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    vld_d   = vld_q;
    to_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|i_req) begin
          state_d     = ST_GRANT;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          id_d        = pick;
          vld_d       = 1'b1;
          cnt_d       = '0;
        end
      end
      ST_GRANT: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Done beats abort beats watchdog; only a pure watchdog release raises o_timeout.
        if (i_done || !i_req[id_q] || to_hit) begin
          state_d = ST_REL;
          gnt_d   = '0;
          vld_d   = 1'b0;
          ptr_d   = id_q + 4'd1;
          to_d    = !i_done && i_req[id_q] && to_hit;
        end
      end
      ST_REL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
    end
  end

  assign o_gnt     = gnt_q;
  assign o_gnt_id  = id_q;
  assign o_gnt_vld = vld_q;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_timeout = to_q;

endmodule

// File: tb/tb_rr_arb16_ctrl.sv
// Bench for rr_arb16_ctrl: transaction-level reference model plus directed scenarios.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// Watchdog shortened to 8 cycles so forced release is reachable quickly.
module tb_rr_arb16_ctrl;
  localparam int TO = 8;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [15:0] i_req = '0;
  logic        i_done = 1'b0;
  logic [15:0] o_gnt;
  logic [3:0]  o_gnt_id;
  logic        o_gnt_vld;
  logic        o_busy;
  logic        o_timeout;

  int checks = 0;
  int errors = 0;

  rr_arb16_ctrl #(.NREQ(16), .TIMEOUT(TO), .CNT_W(11)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (i_req),
    .i_done    (i_done),
    .o_gnt     (o_gnt),
    .o_gnt_id  (o_gnt_id),
    .o_gnt_vld (o_gnt_vld),
    .o_busy    (o_busy),
    .o_timeout (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: who holds the grant, how long, and how many bubble cycles remain.
  bit hold = 0;
  int m_id = 0;
  int m_ptr = 0;
  int m_age = 0;
  int m_cool = 0;
  bit m_to = 0;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold = 0; m_id = 0; m_ptr = 0; m_age = 0; m_cool = 0; m_to = 0;
    end else begin
      bit rel;
      rel  = 0;
      m_to = 0;
      if (hold) begin
        if (i_done) rel = 1;
        else if (!i_req[m_id]) rel = 1;
        else if (TO != 0 && m_age == TO) begin rel = 1; m_to = 1; end
        else m_age = m_age + 1;
        if (rel) begin
          hold   = 0;
          m_ptr  = (m_id + 1) % 16;
          m_cool = 1;
        end
      end else if (m_cool > 0) begin
        m_cool = m_cool - 1;
      end else if (i_req != 0) begin
        for (int k = 15; k >= 0; k--) begin
          if (i_req[(m_ptr + k) % 16]) m_id = (m_ptr + k) % 16;
        end
        hold  = 1;
        m_age = 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      chk("model_vld", {31'd0, o_gnt_vld}, {31'd0, hold});
      chk("model_gnt", {16'd0, o_gnt}, hold ? (32'd1 << m_id) : 32'd0);
      if (hold) chk("model_id", {28'd0, o_gnt_id}, 32'(m_id));
      chk("model_busy", {31'd0, o_busy}, (hold || m_cool > 0) ? 32'd1 : 32'd0);
      chk("model_timeout", {31'd0, o_timeout}, {31'd0, m_to});
    end
  end

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1; i_req = '0; i_done = 1'b0;
    #1;
    chk("rst_gnt", {16'd0, o_gnt}, 32'd0);
    chk("rst_id", {28'd0, o_gnt_id}, 32'd0);
    chk("rst_vld_busy_to", {29'd0, o_gnt_vld, o_busy, o_timeout}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic wait_vld(output int lows);
    lows = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge i_clk);
      if (o_gnt_vld) return;
      lows++;
    end
    checks++;
    errors++;
    $display("FAIL wait_vld actual=no grant required=grant within 40 cycles");
  endtask

  task automatic pulse_done();
    i_done = 1'b1;
    @(negedge i_clk);
    i_done = 1'b0;
  endtask

  initial begin
    int l;
    int hi;

    // 1) single requester, 1-cycle latency, release advances pointer to 1
    do_reset();
    i_req = 16'h0001;
    @(negedge i_clk);
    chk("t1_gnt", {16'd0, o_gnt}, 32'h0001);
    chk("t1_id", {28'd0, o_gnt_id}, 32'd0);
    chk("t1_vld", {31'd0, o_gnt_vld}, 32'd1);
    pulse_done();
    i_req = '0;
    chk("t1_rel_gnt", {16'd0, o_gnt}, 32'd0);
    repeat (2) @(negedge i_clk);
    i_req = 16'h0003;
    wait_vld(l);
    chk("t1_ptr_id", {28'd0, o_gnt_id}, 32'd1);
    i_req = '0;
    repeat (3) @(negedge i_clk);

    // 2) all requesting: ids rotate 0..15,0 with exactly two idle cycles between grants
    do_reset();
    i_req = 16'hFFFF;
    wait_vld(l);
    for (int k = 0; k <= 16; k++) begin
      chk("t2_id", {28'd0, o_gnt_id}, 32'(k % 16));
      if (k < 16) begin
        pulse_done();
        wait_vld(l);
        chk("t2_gap", 32'(l + 1), 32'd2);
      end
    end
    i_req = '0;
    repeat (3) @(negedge i_clk);

    // 3) pointer at 15 wraps to 0
    do_reset();
    i_req = 16'h4000;
    wait_vld(l);
    chk("t3_id14", {28'd0, o_gnt_id}, 32'd14);
    pulse_done();
    i_req = 16'h8001;
    wait_vld(l);
    chk("t3_id15", {28'd0, o_gnt_id}, 32'd15);
    pulse_done();
    wait_vld(l);
    chk("t3_wrap_id0", {28'd0, o_gnt_id}, 32'd0);
    pulse_done();
    i_req = '0;
    repeat (3) @(negedge i_clk);

    // 4) watchdog: grant held 8 cycles, one-cycle timeout pulse, next requester served
    do_reset();
    i_req = 16'h0003;
    wait_vld(l);
    chk("t4_id0", {28'd0, o_gnt_id}, 32'd0);
    hi = 1;
    for (int n = 0; n < 40; n++) begin
      @(negedge i_clk);
      if (!o_gnt_vld) break;
      hi++;
    end
    chk("t4_high_cycles", 32'(hi), 32'd8);
    chk("t4_timeout_hi", {31'd0, o_timeout}, 32'd1);
    @(negedge i_clk);
    chk("t4_timeout_lo", {31'd0, o_timeout}, 32'd0);
    wait_vld(l);
    chk("t4_next_id1", {28'd0, o_gnt_id}, 32'd1);
    i_req = '0;
    repeat (3) @(negedge i_clk);

    // 5a) done coincides with the watchdog cycle: no timeout pulse
    do_reset();
    i_req = 16'h0001;
    wait_vld(l);
    repeat (7) @(negedge i_clk);
    pulse_done();
    chk("t5_done_vld", {31'd0, o_gnt_vld}, 32'd0);
    chk("t5_done_to", {31'd0, o_timeout}, 32'd0);
    @(negedge i_clk);
    chk("t5_done_to2", {31'd0, o_timeout}, 32'd0);
    // 5b) grantee drops its request mid-grant: abort without timeout
    wait_vld(l);
    repeat (2) @(negedge i_clk);
    i_req = '0;
    @(negedge i_clk);
    chk("t5_abort_vld", {31'd0, o_gnt_vld}, 32'd0);
    chk("t5_abort_to", {31'd0, o_timeout}, 32'd0);
    @(negedge i_clk);
    chk("t5_abort_busy", {31'd0, o_busy}, 32'd0);

    // 6) asynchronous reset mid-grant, then pointer restarts at 0
    do_reset();
    i_req = 16'h0020;
    wait_vld(l);
    chk("t6_id5", {28'd0, o_gnt_id}, 32'd5);
    #2;
    i_rst = 1'b1;
    #1;
    chk("t6_async_gnt", {16'd0, o_gnt}, 32'd0);
    chk("t6_async_flags", {29'd0, o_gnt_vld, o_busy, o_timeout}, 32'd0);
    chk("t6_async_id", {28'd0, o_gnt_id}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    i_req = 16'h0010;
    @(negedge i_clk);
    chk("t6_id4", {28'd0, o_gnt_id}, 32'd4);
    chk("t6_gnt", {16'd0, o_gnt}, 32'h0010);
    i_req = '0;
    repeat (3) @(negedge i_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=still running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
